// File: rtl/sdio_data_tx.sv
// sdio_data_tx: 4-bit SDIO DAT block transmitter (start bit, data, per-lane CRC16, end bit).
// Define SDIO_DATA_TX_STATUS_EN to also collect the CRC status token and busy release on DAT0.
module sdio_data_tx #(
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int LEN_W = 12
) (
  input  logic             sd_clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] blk_len,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [3:0]       sd_dat_out,
  output logic             sd_dat_oe,
  input  logic [3:0]       sd_dat_in,
  output logic             busy,
  output logic             done,
  output logic [2:0]       crc_status,
  output logic             crc_error,
  output logic             timeout_error,
  output logic             underrun_error
);
  localparam int CW = LEN_W + 1;
  typedef enum logic [3:0] {IDLE, START, DATA, CRC, END, TURN, STAT_WAIT, STAT, BUSY_WAIT} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, last_cnt;
  logic [LEN_W-1:0] len_q, len_d;
  logic [7:0] byte_q, byte_d;
  logic [3:0][15:0] crc_q, crc_d;
  logic [3:0] nib;
  logic done_q, done_d, und_q, und_d;
  logic unused_din;
  assign unused_din = ^sd_dat_in[3:1];
`ifdef SDIO_DATA_TX_STATUS_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmr_q, tmr_d;
  logic [2:0] sh_q, sh_d, sts_q, sts_d;
  logic cerr_q, cerr_d, terr_q, terr_d, tmo;
  assign tmo = tmr_q == TW'(TIMEOUT_CYCLES - 1);
  assign crc_status = sts_q;
  assign crc_error = cerr_q;
  assign timeout_error = terr_q;
`else
  localparam int unused_tmo = TIMEOUT_CYCLES;
  logic unused_din0;
  assign unused_din0 = sd_dat_in[0];
  assign crc_status = 3'b000;
  assign crc_error = 1'b0;
  assign timeout_error = 1'b0;
`endif
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
  endfunction
  assign nib = cnt_q[0] ? byte_q[3:0] : byte_q[7:4];
  assign last_cnt = {len_q, 1'b0} - CW'(1);
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign underrun_error = und_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    len_d = len_q;
    byte_d = byte_q;
    crc_d = crc_q;
    done_d = 1'b0;
    und_d = und_q;
`ifdef SDIO_DATA_TX_STATUS_EN
    tmr_d = tmr_q;
    sh_d = sh_q;
    sts_d = sts_q;
    cerr_d = cerr_q;
    terr_d = terr_q;
`endif
    sd_dat_out = 4'hF;
    sd_dat_oe = 1'b0;
    tx_ready = 1'b0;
    case (state_q)
      IDLE: if (start && blk_len != '0) begin
        state_d = START;
        len_d = blk_len;
        crc_d = '0;
        und_d = 1'b0;
`ifdef SDIO_DATA_TX_STATUS_EN
        sts_d = 3'b000;
        cerr_d = 1'b0;
        terr_d = 1'b0;
`endif
      end
      START: begin
        sd_dat_out = 4'h0;
        sd_dat_oe = 1'b1;
        tx_ready = 1'b1;
        cnt_d = '0;
        byte_d = tx_valid ? tx_data : byte_q;
        state_d = tx_valid ? DATA : IDLE;
        und_d = !tx_valid;
        done_d = !tx_valid;
      end
      DATA: begin
        sd_dat_out = nib;
        sd_dat_oe = 1'b1;
        tx_ready = cnt_q[0] && cnt_q != last_cnt;
        for (int i = 0; i < 4; i++) crc_d[i] = crc_step(crc_q[i], nib[i]);
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == last_cnt) begin
          cnt_d = '0;
          state_d = CRC;
        end else if (cnt_q[0]) begin
          byte_d = tx_valid ? tx_data : byte_q;
          state_d = tx_valid ? DATA : IDLE;
          und_d = !tx_valid;
          done_d = !tx_valid;
        end
      end
      CRC: begin
        sd_dat_oe = 1'b1;
        for (int i = 0; i < 4; i++) sd_dat_out[i] = crc_q[i][~cnt_q[3:0]];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q[3:0] == 4'd15) state_d = END;
      end
      END: begin
        sd_dat_oe = 1'b1;
        cnt_d = '0;
        state_d = TURN;
      end
      TURN: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q[0]) begin
`ifdef SDIO_DATA_TX_STATUS_EN
          tmr_d = '0;
          state_d = STAT_WAIT;
`else
          done_d = 1'b1;
          state_d = IDLE;
`endif
        end
      end
`ifdef SDIO_DATA_TX_STATUS_EN
      STAT_WAIT: if (!sd_dat_in[0]) begin
        cnt_d = '0;
        state_d = STAT;
      end else if (tmo) begin
        terr_d = 1'b1;
        done_d = 1'b1;
        state_d = IDLE;
      end else tmr_d = tmr_q + TW'(1);
      STAT: begin
        cnt_d = cnt_q + CW'(1);
        sh_d = (cnt_q[1:0] == 2'd3) ? sh_q : {sh_q[1:0], sd_dat_in[0]};
        if (cnt_q[1:0] == 2'd3) begin
          sts_d = sh_q;
          cerr_d = sh_q != 3'b010;
          tmr_d = '0;
          state_d = BUSY_WAIT;
        end
      end
      BUSY_WAIT: if (sd_dat_in[0]) begin
        done_d = 1'b1;
        state_d = IDLE;
      end else if (tmo) begin
        terr_d = 1'b1;
        done_d = 1'b1;
        state_d = IDLE;
      end else tmr_d = tmr_q + TW'(1);
`endif
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge sd_clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      len_q <= '0;
      byte_q <= '0;
      crc_q <= '0;
      done_q <= 1'b0;
      und_q <= 1'b0;
`ifdef SDIO_DATA_TX_STATUS_EN
      tmr_q <= '0;
      sh_q <= '0;
      sts_q <= '0;
      cerr_q <= 1'b0;
      terr_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      len_q <= len_d;
      byte_q <= byte_d;
      crc_q <= crc_d;
      done_q <= done_d;
      und_q <= und_d;
`ifdef SDIO_DATA_TX_STATUS_EN
      tmr_q <= tmr_d;
      sh_q <= sh_d;
      sts_q <= sts_d;
      cerr_q <= cerr_d;
      terr_q <= terr_d;
`endif
    end
  end
endmodule

// File: tb/tb_sdio_data_tx.sv
// tb_sdio_data_tx: table-driven block vectors plus directed reset, zero-length and restart sequences.
module tb_sdio_data_tx;
`ifdef SDIO_DATA_TX_STATUS_EN
  localparam bit S = 1'b1;
`else
  localparam bit S = 1'b0;
`endif
  logic sd_clk = 1'b0, rst = 1'b1, start = 1'b0, tx_valid = 1'b0;
  logic [11:0] blk_len = '0;
  logic [7:0] tx_data = '0;
  logic [3:0] sd_dat_in = 4'hF;
  logic tx_ready, sd_dat_oe, busy, done, crc_error, timeout_error, underrun_error;
  logic [3:0] sd_dat_out;
  logic [2:0] crc_status;
  int n_cmp = 0, n_bad = 0;

  sdio_data_tx #(.TIMEOUT_CYCLES(100), .LEN_W(12)) dut (
    .sd_clk(sd_clk), .rst(rst), .start(start), .blk_len(blk_len),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .sd_dat_out(sd_dat_out), .sd_dat_oe(sd_dat_oe), .sd_dat_in(sd_dat_in),
    .busy(busy), .done(done), .crc_status(crc_status), .crc_error(crc_error),
    .timeout_error(timeout_error), .underrun_error(underrun_error));

  always #5 sd_clk = ~sd_clk;

  typedef struct {
    int len; logic [7:0] first; logic [7:0] step; int drop; logic [2:0] tok; int bsy;
    bit hold_hi; bit rs; int e_oe; int e_hs; int e_done; bit e_und; bit e_cerr; bit e_terr; logic [2:0] e_sts;
  } vec_t;
  vec_t vt [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic logic [15:0] crc16(input logic [15:0] c, input logic b);
    logic fb;
    fb = c[15] ^ b;
    c = c << 1;
    return fb ? c ^ 16'h1021 : c;
  endfunction

  function automatic logic [7:0] bt(input vec_t v, input int i);
    return v.first + 8'(i) * v.step;
  endfunction

  function automatic logic dat0_at(input vec_t v, input int t);
    if (t < 0 || v.hold_hi) return 1'b1;
    if (t == 3) return 1'b0;
    if (t >= 4 && t <= 6) return v.tok[6-t];
    if (t >= 8 && t < 8 + v.bsy) return 1'b0;
    return 1'b1;
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    logic [3:0] cap [0:1099];
    logic [3:0] exp_s [0:1099];
    logic [15:0] mcrc [4];
    logic [15:0] got;
    logic [7:0] b;
    logic [3:0] nb;
    logic [2:0] f_sts;
    logic f_und, f_cerr, f_terr, f_busy;
    int c, hs, n_oe, fall_c, done_c, busy_bad, nbad, k;
    bit fell;
    for (int n = 0; n < 4; n++) mcrc[n] = 16'h0;
    exp_s[0] = 4'h0;
    k = 1;
    for (int i = 0; i < v.len; i++) begin
      b = bt(v, i);
      for (int h = 0; h < 2; h++) begin
        nb = (h == 0) ? b[7:4] : b[3:0];
        exp_s[k] = nb;
        k++;
        for (int n = 0; n < 4; n++) mcrc[n] = crc16(mcrc[n], nb[n]);
      end
    end
    for (int j = 0; j < 16; j++) begin
      for (int n = 0; n < 4; n++) exp_s[k][n] = mcrc[n][15-j];
      k++;
    end
    exp_s[k] = 4'hF;
    hs = 0; n_oe = 0; fall_c = -1; done_c = -1; busy_bad = 0; fell = 0; c = 0;
    f_sts = '0; f_und = 0; f_cerr = 0; f_terr = 0; f_busy = 1;
    @(negedge sd_clk);
    start = 1'b1; blk_len = v.len[11:0]; tx_valid = (v.drop != 0); tx_data = bt(v, 0);
    @(negedge sd_clk);
    while (done_c < 0 && c < 1500) begin
      if (c > 0) @(negedge sd_clk);
      tx_data = bt(v, hs);
      tx_valid = (hs != v.drop);
      start = v.rs && c == 5;
      blk_len = start ? 12'd7 : v.len[11:0];
      sd_dat_in = {3'b111, dat0_at(v, fell ? c - fall_c : -1)};
      #1;
      if (c == 0)
        chk($sformatf("%s start cycle outputs", tag),
            {busy, sd_dat_oe, sd_dat_out, tx_ready, underrun_error, crc_error, timeout_error},
            {1'b1, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0});
      if (!fell) begin
        if (sd_dat_oe) begin
          if (n_oe < 1100) cap[n_oe] = sd_dat_out;
          n_oe++;
        end else begin
          fell = 1;
          fall_c = c;
        end
      end
      if (tx_valid && tx_ready) hs++;
      if (done) begin
        done_c = c;
        f_sts = crc_status; f_und = underrun_error; f_cerr = crc_error; f_terr = timeout_error; f_busy = busy;
      end else if (!busy) busy_bad++;
      c++;
    end
    start = 1'b0;
    sd_dat_in = 4'hF;
    chk($sformatf("%s done seen", tag), done_c >= 0, 1'b1);
    chk($sformatf("%s oe cycles", tag), n_oe, v.e_oe);
    chk($sformatf("%s handshakes", tag), hs, v.e_hs);
    chk($sformatf("%s done offset", tag), done_c - fall_c, v.e_done);
    chk($sformatf("%s busy gaps", tag), busy_bad, 0);
    chk($sformatf("%s busy at done", tag), f_busy, 1'b0);
    chk($sformatf("%s flags und/cerr/terr", tag), {f_und, f_cerr, f_terr}, {v.e_und, v.e_cerr, v.e_terr});
    chk($sformatf("%s crc_status", tag), f_sts, v.e_sts);
    nbad = 0;
    for (int i = 0; i < n_oe && i < v.e_oe && i < 1100; i++) if (cap[i] !== exp_s[i]) nbad++;
    chk($sformatf("%s dat stream errors", tag), nbad, 0);
    if (v.drop < 0 && n_oe >= v.e_oe)
      for (int n = 0; n < 4; n++) begin
        for (int j = 0; j < 16; j++) got[15-j] = cap[2*v.len+1+j][n];
        chk($sformatf("%s lane%0d crc", tag, n), got, mcrc[n]);
      end
    @(negedge sd_clk);
    #1;
    chk($sformatf("%s done width", tag), done, 1'b0);
    tx_valid = 1'b0;
    @(negedge sd_clk);
  endtask

  initial begin
    vt[0] = '{len:1, first:8'hA5, step:8'h00, drop:-1, tok:3'b010, bsy:3, hold_hi:0, rs:0,
              e_oe:20, e_hs:1, e_done:(S ? 12 : 2), e_und:0, e_cerr:0, e_terr:0, e_sts:(S ? 3'b010 : 3'b000)};
    vt[1] = '{len:512, first:8'h00, step:8'h01, drop:-1, tok:3'b010, bsy:1, hold_hi:0, rs:0,
              e_oe:1042, e_hs:512, e_done:(S ? 10 : 2), e_und:0, e_cerr:0, e_terr:0, e_sts:(S ? 3'b010 : 3'b000)};
    vt[2] = '{len:2, first:8'h3C, step:8'h11, drop:-1, tok:3'b101, bsy:2, hold_hi:0, rs:0,
              e_oe:22, e_hs:2, e_done:(S ? 11 : 2), e_und:0, e_cerr:S, e_terr:0, e_sts:(S ? 3'b101 : 3'b000)};
    vt[3] = '{len:4, first:8'h12, step:8'h22, drop:-1, tok:3'b010, bsy:0, hold_hi:1, rs:0,
              e_oe:26, e_hs:4, e_done:(S ? 102 : 2), e_und:0, e_cerr:0, e_terr:S, e_sts:3'b000};
    vt[4] = '{len:8, first:8'h81, step:8'h03, drop:3, tok:3'b010, bsy:0, hold_hi:0, rs:0,
              e_oe:7, e_hs:3, e_done:0, e_und:1, e_cerr:0, e_terr:0, e_sts:3'b000};
    vt[5] = '{len:3, first:8'hF0, step:8'h0F, drop:-1, tok:3'b010, bsy:0, hold_hi:0, rs:1,
              e_oe:24, e_hs:3, e_done:(S ? 9 : 2), e_und:0, e_cerr:0, e_terr:0, e_sts:(S ? 3'b010 : 3'b000)};
    repeat (3) @(negedge sd_clk);
    #1;
    chk("reset values", {sd_dat_out, sd_dat_oe, tx_ready, busy, done, crc_status, crc_error, timeout_error, underrun_error},
        {4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0});
    rst = 1'b0;
    for (int i = 0; i < 6; i++) run_vec(vt[i], $sformatf("vec%0d", i));
    // zero-length request must be ignored entirely
    @(negedge sd_clk);
    start = 1'b1; blk_len = 12'd0;
    @(negedge sd_clk);
    start = 1'b0;
    begin
      int act;
      act = 0;
      for (int i = 0; i < 6; i++) begin
        #1;
        if (busy || done || sd_dat_oe) act++;
        @(negedge sd_clk);
      end
      chk("zero length ignored", act, 0);
    end
    // reset while CRC bits are on the bus
    start = 1'b1; blk_len = 12'd2; tx_valid = 1'b1; tx_data = 8'h5A;
    @(negedge sd_clk);
    start = 1'b0;
    repeat (10) @(negedge sd_clk);
    #1;
    chk("rst pre oe", sd_dat_oe, 1'b1);
    @(negedge sd_clk);
    rst = 1'b1;
    @(posedge sd_clk);
    #1;
    chk("rst edge outputs", {sd_dat_oe, sd_dat_out, busy, done, tx_ready}, {1'b0, 4'hF, 1'b0, 1'b0, 1'b0});
    @(negedge sd_clk);
    rst = 1'b0; tx_valid = 1'b0;
    begin
      int act;
      act = 0;
      for (int i = 0; i < 4; i++) begin
        #1;
        if (done || busy) act++;
        @(negedge sd_clk);
      end
      chk("rst no done", act, 0);
    end
    run_vec(vt[0], "post-rst");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
